// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between instruction fetch and data access.
// Data wins contention except when a starvation guard forces an instruction grant.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [29:0] d_addr,
  input  logic [31:0] d_din,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_dout,
  input  logic        i_req,
  input  logic [29:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_dout,
  output logic [29:0] m_addr,
  output logic [31:0] m_din,
  output logic        m_en,
  output logic        m_we,
  input  logic [31:0] m_dout
);

  logic [3:0]  r_starve_cnt;
  logic        r_rd_d;
  logic        r_rd_i;
  logic [31:0] r_hold_d;
  logic [31:0] r_hold_i;
  logic        w_force_i;

  assign w_force_i = (r_starve_cnt == 4'(STARVE_LIMIT));

  assign d_gnt = ~rst & d_req & (~i_req | ~w_force_i);
  assign i_gnt = ~rst & i_req & (~d_req | w_force_i);

  assign m_en   = d_gnt | i_gnt;
  assign m_we   = d_gnt & d_we;
  assign m_addr = d_gnt ? d_addr : (i_gnt ? i_addr : '0);
  assign m_din  = (d_gnt & d_we) ? d_din : '0;

  assign d_rvalid = r_rd_d;
  assign i_rvalid = r_rd_i;
  // Each port sees live RAM data only in its own return cycle, its hold register otherwise.
  assign d_dout   = r_rd_d ? m_dout : r_hold_d;
  assign i_dout   = r_rd_i ? m_dout : r_hold_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
      r_rd_d       <= 1'b0;
      r_rd_i       <= 1'b0;
      r_hold_d     <= '0;
      r_hold_i     <= '0;
    end else begin
      if (i_gnt || !i_req) begin
        r_starve_cnt <= '0;
      end else if (d_gnt && (r_starve_cnt < 4'(STARVE_LIMIT))) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
      r_rd_d <= d_gnt & ~d_we;
      r_rd_i <= i_gnt;
      if (r_rd_d) r_hold_d <= m_dout;
      if (r_rd_i) r_hold_i <= m_dout;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// against a behavioural model with its own reference memory.
module tb_mem_arbiter;
  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_req, d_we;
  logic [29:0] d_addr;
  logic [31:0] d_din;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_dout;
  logic        i_req;
  logic [29:0] i_addr;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_dout;
  logic [29:0] m_addr;
  logic [31:0] m_din;
  logic        m_en, m_we;
  logic [31:0] m_dout = '0;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: data grants taken while instruction waits, pending/held read values
  int          streak;
  bit          rv_d, rv_i;
  logic [31:0] val_d, val_i, hold_d, hold_i;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_din(d_din),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_dout(d_dout),
    .i_req(i_req), .i_addr(i_addr),
    .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_dout(i_dout),
    .m_addr(m_addr), .m_din(m_din), .m_en(m_en), .m_we(m_we), .m_dout(m_dout)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr[7:0]] <= m_din;
      else      m_dout <= mem[m_addr[7:0]];
    end
  end

  task automatic drive_idle();
    d_req = 0; d_we = 0; d_addr = '0; d_din = '0; i_req = 0; i_addr = '0;
  endtask

  task automatic apply_reset();
    rst = 1;
    drive_idle();
    streak = 0; rv_d = 0; rv_i = 0; val_d = '0; val_i = '0; hold_d = '0; hold_i = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  // Data wins unless instruction has already waited through LIMIT data grants
  function automatic bit want_d();
    return d_req && (!i_req || streak < int'(LIMIT));
  endfunction

  function automatic bit want_i();
    return i_req && (!d_req || streak >= int'(LIMIT));
  endfunction

  task automatic model_edge();
    bit gd, gi;
    gd = want_d();
    gi = want_i();
    if (rv_d) hold_d = val_d;
    if (rv_i) hold_i = val_i;
    rv_d = gd && !d_we;
    if (rv_d) val_d = ref_mem[d_addr[7:0]];
    rv_i = gi;
    if (rv_i) val_i = ref_mem[i_addr[7:0]];
    if (gd && d_we) ref_mem[d_addr[7:0]] = d_din;
    if (gi || !i_req) streak = 0;
    else if (gd) streak++;
  endtask

  task automatic test_reset();
    rst = 1;
    d_req = 1; d_we = 1; d_addr = 30'h5; d_din = 32'hFFFF_0000; i_req = 1; i_addr = 30'h6;
    #1;
    n_tests++;
    if ({d_gnt, i_gnt, m_en, m_we} !== 4'b0 || m_addr !== '0 || m_din !== '0) begin
      n_fail++;
      $display("FAIL reset_drive: got gnt=%b%b en=%b we=%b addr=%h din=%h want all zero",
               d_gnt, i_gnt, m_en, m_we, m_addr, m_din);
    end
    n_tests++;
    if ({d_rvalid, i_rvalid} !== 2'b0 || d_dout !== '0 || i_dout !== '0) begin
      n_fail++;
      $display("FAIL reset_read: got rvalid=%b%b dout=%h/%h want 0", d_rvalid, i_rvalid,
               d_dout, i_dout);
    end
    apply_reset();
  endtask

  task automatic test_ifetch_stream();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      mem[8'h40 + k] = 32'hA0 + k;
      ref_mem[8'h40 + k] = 32'hA0 + k;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 3) begin
        n_tests++;
        if (i_rvalid !== 1'b1 || i_dout !== 32'hA0 + c - 1) begin
          n_fail++;
          $display("FAIL ifetch_data c=%0d: got rvalid=%b dout=%h want 1 %h", c, i_rvalid,
                   i_dout, 32'hA0 + c - 1);
        end
      end
      n_tests++;
      if (d_rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL ifetch_no_drv c=%0d: got %b want 0", c, d_rvalid);
      end
      drive_idle();
      i_req = (c < 3);
      i_addr = 30'h40 + 30'(c);
      #1;
      if (c < 3) begin
        n_tests++;
        if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin
          n_fail++;
          $display("FAIL ifetch_gnt c=%0d: got i=%b d=%b want i=1 d=0", c, i_gnt, d_gnt);
        end
      end
    end
  endtask

  task automatic test_write_read();
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        n_tests++;
        if (d_rvalid !== (c == 2) || d_dout !== 32'hDEADBEEF) begin
          n_fail++;
          $display("FAIL wr_rd_data c=%0d: got rvalid=%b dout=%h want %b deadbeef", c,
                   d_rvalid, d_dout, c == 2);
        end
      end
      drive_idle();
      d_req = (c < 2); d_we = (c == 0); d_addr = 30'h10; d_din = (c == 0) ? 32'hDEADBEEF : '0;
      #1;
      if (c < 2) begin
        n_tests++;
        if (d_gnt !== 1'b1 || m_we !== (c == 0) || m_addr !== 30'h10 ||
            m_din !== ((c == 0) ? 32'hDEADBEEF : 32'h0)) begin
          n_fail++;
          $display("FAIL wr_rd_drive c=%0d: got gnt=%b we=%b addr=%h din=%h", c, d_gnt, m_we,
                   m_addr, m_din);
        end
      end
    end
  endtask

  task automatic test_contention();
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      d_req = 1; d_we = 0; d_addr = 30'h1; i_req = 1; i_addr = 30'h2;
      #1;
      n_tests++;
      if (i_gnt !== ((c % 5) == 4) || d_gnt !== ((c % 5) != 4)) begin
        n_fail++;
        $display("FAIL contention c=%0d: got d=%b i=%b want d=%b i=%b", c, d_gnt, i_gnt,
                 (c % 5) != 4, (c % 5) == 4);
      end
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_hold();
    apply_reset();
    mem[8'h20] = 32'h12345678; ref_mem[8'h20] = 32'h12345678;
    for (int k = 0; k < 6; k++) begin
      mem[8'h30 + k] = $urandom; ref_mem[8'h30 + k] = mem[8'h30 + k];
    end
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c >= 1) begin
        n_tests++;
        if (d_rvalid !== (c == 1) || d_dout !== 32'h12345678) begin
          n_fail++;
          $display("FAIL hold c=%0d: got rvalid=%b dout=%h want %b 12345678", c, d_rvalid,
                   d_dout, c == 1);
        end
      end
      drive_idle();
      d_req = (c == 0); d_addr = 30'h20;
      i_req = (c >= 1 && c <= 5); i_addr = 30'h30 + 30'(c);
    end
  endtask

  task automatic test_starve_reset();
    apply_reset();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      d_req = 1; d_we = 0; d_addr = 30'h3; i_req = (c != 3); i_addr = 30'h4;
      #1;
      n_tests++;
      if (i_gnt !== (c == 8) || d_gnt !== (c != 8)) begin
        n_fail++;
        $display("FAIL starve_reset c=%0d: got d=%b i=%b want d=%b i=%b", c, d_gnt, i_gnt,
                 c != 8, c == 8);
      end
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_async_reset();
    apply_reset();
    mem[8'h40] = 32'hA0; mem[8'h41] = 32'hA1;
    @(negedge clk);
    i_req = 1; i_addr = 30'h40;
    @(negedge clk);
    i_addr = 30'h41;
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    n_tests++;
    if (i_rvalid !== 1'b0 || i_dout !== '0 || i_gnt !== 1'b0 || m_en !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got rvalid=%b dout=%h gnt=%b en=%b want 0", i_rvalid,
               i_dout, i_gnt, m_en);
    end
    drive_idle();
    @(negedge clk);
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if ({i_rvalid, d_rvalid} !== 2'b0 || i_dout !== '0) begin
        n_fail++;
        $display("FAIL async_release c=%0d: got rvalid=%b%b dout=%h want 0", c, i_rvalid,
                 d_rvalid, i_dout);
      end
    end
  endtask

  task automatic test_random();
    bit          gd, gi;
    logic [29:0] exp_addr;
    logic [31:0] exp_din;
    apply_reset();
    for (int k = 128; k < 256; k++) begin
      mem[k] = $urandom; ref_mem[k] = mem[k];
    end
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      n_tests++;
      if (d_rvalid !== rv_d || d_dout !== (rv_d ? val_d : hold_d)) begin
        n_fail++;
        $display("FAIL rand_d_read c=%0d: got rvalid=%b dout=%h want %b %h", c, d_rvalid,
                 d_dout, rv_d, rv_d ? val_d : hold_d);
      end
      n_tests++;
      if (i_rvalid !== rv_i || i_dout !== (rv_i ? val_i : hold_i)) begin
        n_fail++;
        $display("FAIL rand_i_read c=%0d: got rvalid=%b dout=%h want %b %h", c, i_rvalid,
                 i_dout, rv_i, rv_i ? val_i : hold_i);
      end
      d_req = ($urandom_range(0, 9) < 7);
      d_we = ($urandom_range(0, 3) == 0);
      d_addr = 30'h80 + 30'($urandom_range(0, 127));
      d_din = $urandom;
      i_req = ($urandom_range(0, 9) < 7);
      i_addr = 30'h80 + 30'($urandom_range(0, 127));
      gd = want_d();
      gi = want_i();
      exp_addr = gd ? d_addr : (gi ? i_addr : '0);
      exp_din = (gd && d_we) ? d_din : '0;
      #1;
      n_tests++;
      if ({d_gnt, i_gnt} !== {gd, gi}) begin
        n_fail++;
        $display("FAIL rand_gnt c=%0d: got d=%b i=%b want d=%b i=%b", c, d_gnt, i_gnt, gd, gi);
      end
      n_tests++;
      if (m_en !== (gd | gi) || m_we !== (gd && d_we) || m_addr !== exp_addr ||
          m_din !== exp_din) begin
        n_fail++;
        $display("FAIL rand_mem c=%0d: got en=%b we=%b addr=%h din=%h want %b %b %h %h", c,
                 m_en, m_we, m_addr, m_din, gd | gi, gd && d_we, exp_addr, exp_din);
      end
      model_edge();
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin
      mem[k] = '0; ref_mem[k] = '0;
    end
    rst = 1;
    drive_idle();
    test_reset();
    test_ifetch_stream();
    test_write_read();
    test_contention();
    test_hold();
    test_starve_reset();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
